// File: rtl/shift_register.sv
// Bidirectional serial-in shift register with parallel load, registered serial output
// and a saturating shift counter that flags when WIDTH shifts have accumulated.
module shift_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    input  logic             shift_enable,
    input  logic             shift_dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out,
    output logic             full
);

    // Counter must hold the value WIDTH itself, hence WIDTH+1 states.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(WIDTH);

    logic [WIDTH-1:0] data_next;
    logic             serial_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;

    always_comb begin
        data_next   = data_out;
        serial_next = serial_out;
        count_next  = count;
        if (load) begin
            data_next  = load_data;
            count_next = '0;
        end else if (shift_enable) begin
            if (shift_dir) begin
                data_next   = {data_in, data_out[WIDTH-1:1]};
                serial_next = data_out[0];
            end else begin
                data_next   = {data_out[WIDTH-2:0], data_in};
                serial_next = data_out[WIDTH-1];
            end
            if (count != FULL_COUNT) begin
                count_next = count + 1'b1;
            end
        end
    end

    // full is registered from the next count so it tracks count with no extra lag.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            serial_out <= 1'b0;
            count      <= '0;
            full       <= 1'b0;
        end else begin
            data_out   <= data_next;
            serial_out <= serial_next;
            count      <= count_next;
            full       <= (count_next == FULL_COUNT);
        end
    end

endmodule

// File: tb/tb_shift_register.sv
// Directed bench for shift_register: a vector table walked edge by edge, then
// hand-written sequences for counter clearing, right-shift latency and reset timing.
module tb_shift_register;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         data_in;
    logic         shift_enable;
    logic         shift_dir;
    logic         load;
    logic [W-1:0] load_data;
    logic [W-1:0] data_out;
    logic         serial_out;
    logic         full;

    int tests;
    int fails;

    typedef struct {
        logic         rst;
        logic         ld;
        logic         en;
        logic         dir;
        logic         din;
        logic [W-1:0] ldata;
        logic [W-1:0] exp_data;
        logic         exp_serial;
        logic         exp_full;
    } vec_t;

    vec_t vecs[$];

    shift_register #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .shift_enable (shift_enable),
        .shift_dir    (shift_dir),
        .load         (load),
        .load_data    (load_data),
        .data_out     (data_out),
        .serial_out   (serial_out),
        .full         (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic ld, input logic en, input logic dir,
                         input logic din, input logic [W-1:0] ldata);
        reset        = rst;
        load         = ld;
        shift_enable = en;
        shift_dir    = dir;
        data_in      = din;
        load_data    = ldata;
    endtask

    task automatic edge_step(input logic rst, input logic ld, input logic en, input logic dir,
                             input logic din, input logic [W-1:0] ldata);
        drive(rst, ld, en, dir, din, ldata);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic rst, input logic ld, input logic en, input logic dir,
                       input logic din, input logic [W-1:0] ldata,
                       input logic [W-1:0] ed, input logic es, input logic ef);
        vec_t v;
        v.rst = rst; v.ld = ld; v.en = en; v.dir = dir; v.din = din; v.ldata = ldata;
        v.exp_data = ed; v.exp_serial = es; v.exp_full = ef;
        vecs.push_back(v);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        //   rst ld en dir din ldata   data   ser full
        add(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        // Fill with ones shifting left.
        add(0, 0, 1, 0, 1, 8'h00, 8'h01, 0, 0);
        add(0, 0, 1, 0, 1, 8'h00, 8'h03, 0, 0);
        add(0, 0, 1, 0, 1, 8'h00, 8'h07, 0, 0);
        add(0, 0, 1, 0, 1, 8'h00, 8'h0F, 0, 0);
        add(0, 0, 1, 0, 1, 8'h00, 8'h1F, 0, 0);
        add(0, 0, 1, 0, 1, 8'h00, 8'h3F, 0, 0);
        add(0, 0, 1, 0, 1, 8'h00, 8'h7F, 0, 0);
        add(0, 0, 1, 0, 1, 8'h00, 8'hFF, 0, 1);
        add(1, 0, 1, 0, 1, 8'h00, 8'h00, 0, 0);
        // Alternating pattern 0,1,0,1,...
        add(0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0);
        add(0, 0, 1, 0, 1, 8'h00, 8'h01, 0, 0);
        add(0, 0, 1, 0, 0, 8'h00, 8'h02, 0, 0);
        add(0, 0, 1, 0, 1, 8'h00, 8'h05, 0, 0);
        add(0, 0, 1, 0, 0, 8'h00, 8'h0A, 0, 0);
        add(0, 0, 1, 0, 1, 8'h00, 8'h15, 0, 0);
        add(0, 0, 1, 0, 0, 8'h00, 8'h2A, 0, 0);
        add(0, 0, 1, 0, 1, 8'h00, 8'h55, 0, 1);
        // Hold with data_in / shift_dir wiggling.
        add(0, 0, 0, 1, 1, 8'h00, 8'h55, 0, 1);
        add(0, 0, 0, 0, 0, 8'h00, 8'h55, 0, 1);
        add(0, 0, 0, 1, 1, 8'h00, 8'h55, 0, 1);
        // Saturated counter keeps full high; direction changes per edge.
        add(0, 0, 1, 0, 0, 8'h00, 8'hAA, 0, 1);
        add(0, 0, 1, 0, 1, 8'h00, 8'h55, 1, 1);
        add(0, 0, 1, 1, 1, 8'h00, 8'hAA, 1, 1);
        // One shift, then reset with shift_enable still high.
        add(0, 0, 1, 0, 1, 8'h00, 8'h55, 1, 1);
        add(1, 0, 1, 0, 1, 8'h00, 8'h00, 0, 0);
        // Load then shift right with zeros.
        add(0, 1, 0, 0, 0, 8'h81, 8'h81, 0, 0);
        add(0, 0, 1, 1, 0, 8'h00, 8'h40, 1, 0);
        add(0, 0, 1, 1, 0, 8'h00, 8'h20, 0, 0);
        // Get serial_out to 1, then load with shift_enable: load wins, serial holds.
        add(0, 1, 0, 0, 0, 8'h01, 8'h01, 0, 0);
        add(0, 0, 1, 1, 0, 8'h00, 8'h00, 1, 0);
        add(0, 1, 1, 0, 1, 8'hA5, 8'hA5, 1, 0);

        foreach (vecs[i]) begin
            edge_step(vecs[i].rst, vecs[i].ld, vecs[i].en, vecs[i].dir, vecs[i].din, vecs[i].ldata);
            check($sformatf("vec%0d data_out", i), data_out, vecs[i].exp_data);
            check($sformatf("vec%0d serial_out", i), W'(serial_out), W'(vecs[i].exp_serial));
            check($sformatf("vec%0d full", i), W'(full), W'(vecs[i].exp_full));
        end

        // Counter cleared by the load: hold one edge, then 8 left shifts of zeros.
        edge_step(0, 0, 0, 0, 1, 8'h00);
        check("post_load_hold full", W'(full), W'(0));
        for (int k = 1; k <= 7; k++) begin
            edge_step(0, 0, 1, 0, 0, 8'h00);
            check($sformatf("post_load_shift%0d full", k), W'(full), W'(0));
        end
        check("post_load_shift7 data", data_out, 8'h80);
        edge_step(0, 0, 1, 0, 0, 8'h00);
        check("post_load_shift8 full", W'(full), W'(1));
        check("post_load_shift8 data", data_out, 8'h00);
        check("post_load_shift8 serial", W'(serial_out), W'(1));

        // Right-shift latency: a single one travels from MSB to LSB in WIDTH shifts.
        edge_step(1, 0, 0, 0, 0, 8'h00);
        edge_step(0, 0, 1, 1, 1, 8'h00);
        check("right_lat edge1 data", data_out, 8'h80);
        for (int k = 2; k <= W; k++) begin
            edge_step(0, 0, 1, 1, 0, 8'h00);
        end
        check("right_lat edge8 data", data_out, 8'h01);
        check("right_lat edge8 full", W'(full), W'(1));
        edge_step(0, 0, 1, 1, 0, 8'h00);
        check("right_lat exit data", data_out, 8'h00);
        check("right_lat exit serial", W'(serial_out), W'(1));

        // Reset has no effect between edges.
        edge_step(0, 1, 0, 0, 0, 8'h3C);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 8'h00);
        #1;
        check("reset_sync before edge data", data_out, 8'h3C);
        @(posedge clk);
        #1;
        check("reset_sync after edge data", data_out, 8'h00);
        // Shifting resumes on the first edge after reset deasserts.
        edge_step(0, 0, 1, 0, 1, 8'h00);
        check("reset_resume data", data_out, 8'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
